// File: rtl/spi_slave_frontend.sv
// SPI mode-0 slave front end that turns 16-bit command frames into
// register-map read/write strobes. All SPI pins are synchronised into clk
// and edges are found on the synchronised copies only.
module spi_slave_frontend #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck_i,
    input  logic                  sdi_i,
    input  logic                  cs_ni,
    output logic                  sdo_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  reg_we_o,
    output logic                  reg_re_o,
    input  logic [DATA_WIDTH-1:0] reg_rdata_i,
    output logic                  frame_err_o
);

    localparam int FRAME_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CMD_BITS = 1 + ADDR_WIDTH;
    localparam int CNT_W    = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        DATA,
        WAIT_CS
    } state_e;

    logic [SYNC_STAGES-1:0] sckSync_q;
    logic [SYNC_STAGES-1:0] sdiSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic                   sckPrev_q;
    logic                   csPrev_q;

    state_e                 state_q,     state_d;
    logic [CNT_W-1:0]       bitCnt_q,    bitCnt_d;
    logic [FRAME_W-1:0]     rxShift_q,   rxShift_d;
    logic [DATA_WIDTH-1:0]  txShift_q,   txShift_d;
    logic                   sdo_q,       sdo_d;
    logic [ADDR_WIDTH-1:0]  regAddr_q,   regAddr_d;
    logic [DATA_WIDTH-1:0]  regWdata_q,  regWdata_d;
    logic                   regWe_q,     regWe_d;
    logic                   regRe_q,     regRe_d;
    logic                   frameErr_q,  frameErr_d;

    logic                   sckRise, sckFall, csRise, csFall, sdiS;
    logic [FRAME_W-1:0]     rxNext;

    // Synchronise the three SPI pins and keep one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sckSync_q <= '0;
            sdiSync_q <= '0;
            csSync_q  <= '1;
            sckPrev_q <= 1'b0;
            csPrev_q  <= 1'b1;
        end else begin
            sckSync_q[0] <= sck_i;
            sdiSync_q[0] <= sdi_i;
            csSync_q[0]  <= cs_ni;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sckSync_q[i] <= sckSync_q[i-1];
                sdiSync_q[i] <= sdiSync_q[i-1];
                csSync_q[i]  <= csSync_q[i-1];
            end
            sckPrev_q <= sckSync_q[SYNC_STAGES-1];
            csPrev_q  <= csSync_q[SYNC_STAGES-1];
        end
    end

    assign sckRise = sckSync_q[SYNC_STAGES-1] & ~sckPrev_q;
    assign sckFall = ~sckSync_q[SYNC_STAGES-1] & sckPrev_q;
    assign csFall  = ~csSync_q[SYNC_STAGES-1] & csPrev_q;
    assign csRise  = csSync_q[SYNC_STAGES-1] & ~csPrev_q;
    assign sdiS    = sdiSync_q[SYNC_STAGES-1];
    assign rxNext  = {rxShift_q[FRAME_W-2:0], sdiS};

    // Frame sequencing: next state, shifters, strobes and sdo for this cycle
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        sdo_d      = sdo_q;
        regAddr_d  = regAddr_q;
        regWdata_d = regWdata_q;
        regWe_d    = 1'b0;
        regRe_d    = 1'b0;
        frameErr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csFall) begin
                    state_d   = CMD;
                    bitCnt_d  = '0;
                    rxShift_d = '0;
                    txShift_d = '0;
                end
            end
            CMD: begin
                if (csRise) begin
                    state_d    = IDLE;
                    frameErr_d = 1'b1;
                end else if (sckRise) begin
                    rxShift_d = rxNext;
                    bitCnt_d  = bitCnt_q + CNT_W'(1);
                    if (bitCnt_q == CNT_W'(CMD_BITS - 1)) begin
                        if (rxNext[ADDR_WIDTH]) begin
                            state_d   = FETCH;
                            regRe_d   = 1'b1;
                            regAddr_d = rxNext[ADDR_WIDTH-1:0];
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            FETCH: begin
                if (csRise) begin
                    state_d    = IDLE;
                    frameErr_d = 1'b1;
                end else if (!regRe_q) begin
                    txShift_d = reg_rdata_i;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (csRise) begin
                    state_d    = IDLE;
                    frameErr_d = 1'b1;
                end else begin
                    if (sckFall) begin
                        sdo_d     = txShift_q[DATA_WIDTH-1];
                        txShift_d = txShift_q << 1;
                    end
                    if (sckRise) begin
                        rxShift_d = rxNext;
                        bitCnt_d  = bitCnt_q + CNT_W'(1);
                        if (bitCnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = WAIT_CS;
                            if (!rxNext[FRAME_W-1]) begin
                                regWe_d    = 1'b1;
                                regAddr_d  = rxNext[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
                                regWdata_d = rxNext[DATA_WIDTH-1:0];
                            end
                        end
                    end
                end
            end
            WAIT_CS: begin
                if (csRise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE || state_d == CMD || state_d == WAIT_CS) begin
            sdo_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            sdo_q      <= 1'b0;
            regAddr_q  <= '0;
            regWdata_q <= '0;
            regWe_q    <= 1'b0;
            regRe_q    <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            sdo_q      <= sdo_d;
            regAddr_q  <= regAddr_d;
            regWdata_q <= regWdata_d;
            regWe_q    <= regWe_d;
            regRe_q    <= regRe_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign sdo_o       = sdo_q;
    assign reg_addr_o  = regAddr_q;
    assign reg_wdata_o = regWdata_q;
    assign reg_we_o    = regWe_q;
    assign reg_re_o    = regRe_q;
    assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Bench for spi_slave_frontend: an SPI master drives frames, a register-map
// responder returns per-address read data, and a monitor logs strobes.
`timescale 1ns/1ps
module tb_spi_slave_frontend;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        int         half;
        int         expWrites;
        int         expReads;
        int         expFerr;
        logic [7:0] expData;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       sck;
    logic       sdi;
    logic       cs_n;
    logic       sdo;
    logic [6:0] regAddr;
    logic [7:0] regWdata;
    logic       regWe;
    logic       regRe;
    logic [7:0] regRdata;
    logic       frameErr;

    logic [7:0] rdMem [128];

    int checks = 0;
    int errors = 0;
    int weCount = 0;
    int reCount = 0;
    int ferrCount = 0;
    int overlapCount = 0;
    logic [6:0] lastWeAddr;
    logic [7:0] lastWeData;
    logic [6:0] lastReAddr;

    spi_slave_frontend #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck_i      (sck),
        .sdi_i      (sdi),
        .cs_ni      (cs_n),
        .sdo_o      (sdo),
        .reg_addr_o (regAddr),
        .reg_wdata_o(regWdata),
        .reg_we_o   (regWe),
        .reg_re_o   (regRe),
        .reg_rdata_i(regRdata),
        .frame_err_o(frameErr)
    );

    // 10 MHz system clock
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Register map responder: data is valid only in the cycle after a read strobe
    always @(posedge clk) begin
        regRdata <= regRe ? rdMem[regAddr] : 8'($urandom);
    end

    // Strobe monitor sampling on the falling clock edge
    always @(negedge clk) begin
        if (regWe) begin
            weCount++;
            lastWeAddr = regAddr;
            lastWeData = regWdata;
        end
        if (regRe) begin
            reCount++;
            lastReAddr = regAddr;
        end
        if (frameErr) ferrCount++;
        if (regWe && regRe) overlapCount++;
    end

    // Global time limit so the bench cannot hang
    initial begin
        #5000000;
        $display("[TB] FAIL timeout reached got=running exp=finished");
        $fatal(1, "[TB] time limit");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected behaviour of a frame from the protocol rules alone
    function automatic vec_t modelVec(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                                      input int nbits, input int half);
        vec_t v;
        v.rw        = rw;
        v.addr      = addr;
        v.data      = data;
        v.nbits     = nbits;
        v.half      = half;
        v.expWrites = (nbits >= 16 && !rw) ? 1 : 0;
        v.expReads  = (nbits >= 8 && rw) ? 1 : 0;
        v.expFerr   = (nbits < 16) ? 1 : 0;
        v.expData   = rw ? rdMem[addr] : data;
        return v;
    endfunction

    function automatic vec_t mkVec(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                                   input int nbits, input int half, input int ew, input int er,
                                   input int ef, input logic [7:0] ed);
        vec_t v;
        v.rw        = rw;
        v.addr      = addr;
        v.data      = data;
        v.nbits     = nbits;
        v.half      = half;
        v.expWrites = ew;
        v.expReads  = er;
        v.expFerr   = ef;
        v.expData   = ed;
        return v;
    endfunction

    // Drive one SPI mode-0 frame; sdo is captured just before each sck rise
    task automatic applyStimulus(input vec_t v, output logic [31:0] miso);
        logic [15:0] frame;
        frame = {v.rw, v.addr, v.data};
        miso  = '0;
        cs_n  = 1'b0;
        waitClk(v.half);
        for (int i = 0; i < v.nbits; i++) begin
            sdi = (i < 16) ? frame[15-i] : 1'($urandom);
            waitClk(v.half);
            miso[i] = sdo;
            sck = 1'b1;
            waitClk(v.half);
            sck = 1'b0;
        end
        waitClk(v.half);
        cs_n = 1'b1;
        waitClk(12);
    endtask

    task automatic checkFrame(input vec_t v, input int idx, input logic [31:0] miso,
                              input int we0, input int re0, input int fe0, input int ov0);
        logic [7:0]  rdGot;
        logic [31:0] idleMask;
        checkOutput($sformatf("v%0d.writes", idx), 32'(weCount - we0), 32'(v.expWrites));
        checkOutput($sformatf("v%0d.reads", idx), 32'(reCount - re0), 32'(v.expReads));
        checkOutput($sformatf("v%0d.frameErr", idx), 32'(ferrCount - fe0), 32'(v.expFerr));
        checkOutput($sformatf("v%0d.weReOverlap", idx), 32'(overlapCount - ov0), 32'd0);
        if (v.expWrites == 1) begin
            checkOutput($sformatf("v%0d.wrAddr", idx), 32'(lastWeAddr), 32'(v.addr));
            checkOutput($sformatf("v%0d.wrData", idx), 32'(lastWeData), 32'(v.expData));
        end
        if (v.expReads == 1) begin
            checkOutput($sformatf("v%0d.rdAddr", idx), 32'(lastReAddr), 32'(v.addr));
        end
        if (v.expReads == 1 && v.nbits >= 16) begin
            for (int j = 0; j < 8; j++) rdGot[7-j] = miso[8+j];
            checkOutput($sformatf("v%0d.sdoData", idx), 32'(rdGot), 32'(v.expData));
        end
        idleMask = '0;
        for (int i = 0; i < v.nbits && i < 32; i++) begin
            if (i < 8 || i >= 16) idleMask[i] = 1'b1;
        end
        if (idleMask != 0) begin
            checkOutput($sformatf("v%0d.sdoIdle", idx), miso & idleMask, 32'd0);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        logic [31:0] miso;
        logic [15:0] frame;
        int          we0, re0, fe0, ov0, nb, sel;

        rst_n = 1'b1;
        sck   = 1'b0;
        sdi   = 1'b0;
        cs_n  = 1'b1;
        for (int a = 0; a < 128; a++) rdMem[a] = 8'($urandom);
        rdMem[7'h05] = 8'hA5;
        rdMem[7'h70] = 8'hFF;
        rdMem[7'h60] = 8'h00;
        rdMem[7'h7F] = 8'h3C;
        rdMem[7'h33] = 8'h81;

        #5 rst_n = 1'b0;
        #5;
        checkOutput("rst.sdo", 32'(sdo), 32'd0);
        checkOutput("rst.we", 32'(regWe), 32'd0);
        checkOutput("rst.re", 32'(regRe), 32'd0);
        checkOutput("rst.ferr", 32'(frameErr), 32'd0);
        checkOutput("rst.addr", 32'(regAddr), 32'd0);
        checkOutput("rst.wdata", 32'(regWdata), 32'd0);
        waitClk(5);
        rst_n = 1'b1;
        waitClk(10);

        // Directed frames with hand-derived expectations
        vecs.push_back(mkVec(1'b0, 7'h05, 8'hA5, 16, 5, 1, 0, 0, 8'hA5));
        vecs.push_back(mkVec(1'b1, 7'h05, 8'h00, 16, 5, 0, 1, 0, 8'hA5));
        vecs.push_back(mkVec(1'b1, 7'h70, 8'h00, 16, 5, 0, 1, 0, 8'hFF));
        vecs.push_back(mkVec(1'b1, 7'h60, 8'h00, 16, 5, 0, 1, 0, 8'h00));
        vecs.push_back(mkVec(1'b0, 7'h05, 8'hA5, 10, 5, 0, 0, 1, 8'hA5));
        vecs.push_back(mkVec(1'b0, 7'h05, 8'hA5, 16, 5, 1, 0, 0, 8'hA5));
        vecs.push_back(mkVec(1'b0, 7'h01, 8'h12, 20, 5, 1, 0, 0, 8'h12));
        vecs.push_back(mkVec(1'b1, 7'h33, 8'h00, 12, 6, 0, 1, 1, 8'h81));
        vecs.push_back(mkVec(1'b0, 7'h00, 8'h00, 0, 5, 0, 0, 1, 8'h00));
        vecs.push_back(mkVec(1'b1, 7'h7F, 8'h00, 16, 7, 0, 1, 0, 8'h3C));
        vecs.push_back(mkVec(1'b1, 7'h22, 8'h00, 7, 5, 0, 0, 1, 8'h00));

        // Randomised frames whose expectations come from the model
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) nb = 16;
            else if (sel < 8) nb = $urandom_range(1, 15);
            else nb = $urandom_range(17, 20);
            vecs.push_back(modelVec(1'($urandom), 7'($urandom), 8'($urandom), nb, $urandom_range(5, 8)));
        end

        foreach (vecs[i]) begin
            we0 = weCount;
            re0 = reCount;
            fe0 = ferrCount;
            ov0 = overlapCount;
            applyStimulus(vecs[i], miso);
            checkFrame(vecs[i], i, miso, we0, re0, fe0, ov0);
        end

        // Reset in the middle of a write frame, after the 12th sck rise
        $display("[TB] reset mid-frame sequence");
        we0   = weCount;
        re0   = reCount;
        fe0   = ferrCount;
        frame = {1'b0, 7'h22, 8'h5A};
        cs_n  = 1'b0;
        waitClk(5);
        for (int i = 0; i < 12; i++) begin
            sdi = frame[15-i];
            waitClk(5);
            sck = 1'b1;
            if (i < 11) begin
                waitClk(5);
                sck = 1'b0;
            end
        end
        waitClk(4);
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.sdo", 32'(sdo), 32'd0);
        checkOutput("midRst.we", 32'(regWe), 32'd0);
        checkOutput("midRst.re", 32'(regRe), 32'd0);
        checkOutput("midRst.ferr", 32'(frameErr), 32'd0);
        checkOutput("midRst.addr", 32'(regAddr), 32'd0);
        checkOutput("midRst.wdata", 32'(regWdata), 32'd0);
        sck  = 1'b0;
        cs_n = 1'b1;
        waitClk(6);
        rst_n = 1'b1;
        waitClk(12);
        checkOutput("midRst.noWrite", 32'(weCount - we0), 32'd0);
        checkOutput("midRst.noRead", 32'(reCount - re0), 32'd0);
        checkOutput("midRst.noFerr", 32'(ferrCount - fe0), 32'd0);

        v   = mkVec(1'b1, 7'h05, 8'h00, 16, 5, 0, 1, 0, 8'hA5);
        we0 = weCount;
        re0 = reCount;
        fe0 = ferrCount;
        ov0 = overlapCount;
        applyStimulus(v, miso);
        checkFrame(v, 99, miso, we0, re0, fe0, ov0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_frontend.md
SPI_SLAVE_FRONTEND -- requirements
Module: spi_slave_frontend

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, register data width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops per synchroniser on sck_i/sdi_i/cs_ni.
REQ-004 SHALL have port clk, input, 1, sole system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sck_i, input, 1, SPI clock, asynchronous to clk.
REQ-007 SHALL have port sdi_i, input, 1, SPI serial data in.
REQ-008 SHALL have port cs_ni, input, 1, SPI chip select, active low.
REQ-009 SHALL have port sdo_o, output, 1, SPI serial data out.
REQ-010 SHALL have port reg_addr_o, output, ADDR_WIDTH, register-map address.
REQ-011 SHALL have port reg_wdata_o, output, DATA_WIDTH, register-map write data.
REQ-012 SHALL have port reg_we_o, output, 1, one-cycle write strobe.
REQ-013 SHALL have port reg_re_o, output, 1, one-cycle read strobe.
REQ-014 SHALL have port reg_rdata_i, input, DATA_WIDTH, read data, valid the cycle after reg_re_o.
REQ-015 SHALL have port frame_err_o, output, 1, one-cycle pulse on aborted frame.

Function
REQ-016 SHALL implement SPI mode 0: sdi sampled on synchronised sck rising edge, sdo updated on synchronised sck falling edge, MSB first.
REQ-017 SHALL use frame width F = 1+ADDR_WIDTH+DATA_WIDTH (16): bit F-1 = R/W (1 read, 0 write), then address, then data.
REQ-018 SHALL detect sck/cs_n edges from the synchronised signals only; edge-to-action latency at most SYNC_STAGES+1 clk cycles.
REQ-019 SHALL operate correctly when each sck high and low phase lasts at least SYNC_STAGES+3 clk periods.
REQ-020 SHALL use states IDLE, CMD, FETCH, DATA, WAIT_CS.
REQ-021 IDLE -> CMD on synchronised cs_n falling; bit counter cleared to 0.
REQ-022 CMD: shift 1+ADDR_WIDTH bits; after last address bit -> FETCH if read, DATA if write.
REQ-023 FETCH: assert reg_re_o one cycle with reg_addr_o = received address, capture reg_rdata_i next cycle into tx shifter, -> DATA; complete before the following sck falling edge.
REQ-024 DATA: on each sck falling edge drive next tx bit on sdo_o (first falling edge after the last address bit drives data MSB); on rising edges shift DATA_WIDTH bits of sdi.
REQ-025 After F-th rising edge: write frame -> reg_we_o one cycle with reg_addr_o/reg_wdata_o valid that cycle; read frame -> no write; both -> WAIT_CS.
REQ-026 WAIT_CS: ignore further sck edges; -> IDLE on cs_n rising.
REQ-027 cs_n rising in CMD, FETCH or DATA SHALL -> IDLE, pulse frame_err_o one cycle, suppress reg_we_o.
REQ-028 reg_addr_o and reg_wdata_o SHALL hold their last values between strobes.
REQ-029 sdo_o SHALL be 0 whenever state is IDLE, CMD or WAIT_CS.
REQ-030 reg_we_o and reg_re_o SHALL never both be high, and each at most once per frame.
REQ-031 sdo_o during read of unmapped address SHALL equal reg_rdata_i as captured, no substitution.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, sdo_o=0, reg_we_o=0, reg_re_o=0, frame_err_o=0, reg_addr_o=0, reg_wdata_o=0, counters and shifters 0, synchroniser flops to cs_n=1/sck=0/sdi=0.
REQ-033 Reset mid-frame SHALL discard the frame without strobe or frame_err_o; next frame requires fresh cs_n falling edge.

Verification
REQ-034 Write frame {0,7'h05,8'hA5}, sck 1 MHz, clk 10 MHz -> exactly one reg_we_o with addr 0x05, wdata 0xA5; no reg_re_o.
REQ-035 Read frame {1,7'h05,8'h00}, reg_rdata_i=0xA5 next cycle after reg_re_o -> one reg_re_o at addr 0x05; bits sampled on rises 9-16 = 0xA5.
REQ-036 Read addr 0x70 with reg_rdata_i=0xFF -> sdo bits 9-16 = 0xFF; addr 0x60 with 0x00 -> 0x00.
REQ-037 cs_n raised after 10 sck cycles of write frame -> no reg_we_o, one frame_err_o pulse, state IDLE; next full write succeeds.
REQ-038 20 sck cycles in one cs_n window, write 0x12 to 0x01 -> single reg_we_o after 16th rise, extra edges ignored, no frame_err_o.
REQ-039 rst_n low at sck cycle 12 of a write -> all outputs 0 at once, no strobe; subsequent read returns correct data.
